updn_sweep_ctrl: RTL
====================

# updn_sweep_ctrl

Sequencing controller for the board's 3-bit up/down counter. It replaces the free-running up_dn switch with programmed sweeps between runtime bounds lo and hi. Four modes are supported: wrap-up, wrap-down, bounce, and one-shot. It provides start/stop/hold control, lap counting and completion/error pulses. It runs in the slow_clk domain, fed by the board's clock divider, and its count output drives the LED display.

## Interface
- W, default 3, counter width
- LAPW, default 4, lap-counter width

- slow_clk  in  1  divided board clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a sequence; sampled only in IDLE
- stop  in  1  abort running sequence; count freezes at current value
- hold  in  1  level; while high, state, cnt and laps freeze
- mode  in  2  00 WRAP_UP, 01 WRAP_DN, 10 BOUNCE, 11 ONESHOT; latched on start
- lo  in  W  lower bound; latched on start
- hi  in  W  upper bound; latched on start
- cnt  out  W  current count
- up_dn  out  1  current direction: 1 up, 0 down
- busy  out  1  high in UP or DOWN state
- done  out  1  one-cycle pulse at ONESHOT completion
- err  out  1  one-cycle pulse when start is rejected
- laps  out  LAPW  completed laps; saturating

## Operation
- States: IDLE, UP, DOWN.
- Reset values: state IDLE, cnt 0, up_dn 1, busy 0, done 0, err 0, laps 0, latched mode/lo/hi 0.
- **IDLE**
  - start=1, stop=0, lo≤hi: latch mode, lo and hi; clear laps.
    - Modes WRAP_UP, BOUNCE, ONESHOT: cnt←lo, go to UP.
    - Mode WRAP_DN: cnt←hi, go to DOWN.
  - start=1 with lo>hi: err=1 for one cycle; stay in IDLE; cnt unchanged.
  - start and stop together: stop wins; nothing happens, no err.
- **UP** (hold=0), each edge:
  - cnt<hi: cnt←cnt+1.
  - cnt==hi, WRAP_UP: cnt←lo, laps+1.
  - cnt==hi, BOUNCE/ONESHOT: cnt←cnt−1, go to DOWN.
  - When lo==hi in bounce/one-shot: go to DOWN with cnt unchanged.
- **DOWN** (hold=0), each edge:
  - cnt>lo: cnt←cnt−1.
  - cnt==lo, WRAP_DN: cnt←hi, laps+1.
  - cnt==lo, BOUNCE: cnt←cnt+1 (unchanged if lo==hi), go to UP, laps+1.
  - cnt==lo, ONESHOT: go to IDLE, cnt stays lo, laps+1, done=1.
- stop=1 in UP or DOWN: go to IDLE; cnt, laps and up_dn hold. Takes priority over hold.
- hold=1: no state, cnt or laps change. start is ignored outside IDLE.
- Arithmetic never leaves [lo,hi], so no modular wrap past 0 or 2^W−1 occurs.
- laps saturates at 2^LAPW−1.
- up_dn is 1 in UP and 0 in DOWN; it keeps its last value in IDLE.

## Timing
- Every output is registered.
- Start accepted at edge k: cnt=lo (or hi) and busy=1 visible after edge k; first step at edge k+1.
- Turnaround has zero dwell: hi appears for exactly one cycle per pass, and so does lo mid-bounce.
- ONESHOT over span n=hi−lo (n>0): done asserts after edge k+2n+1, for one cycle. busy is 0 from that same edge.
- err asserts the cycle after the rejected start edge.
- rst mid-sequence: all outputs return to their reset values at that edge. A start in the same cycle is ignored.

## Structure
- Package updn_sweep_pkg holds:
  - mode encodings: MODE_WRAP_UP, MODE_WRAP_DN, MODE_BOUNCE, MODE_ONESHOT
  - state enum
- Sub-module updn_cnt_ld: W-bit counter with inputs en, up_dn, ld, ld_val, synchronous active-high rst on slow_clk. It owns cnt. The controller FSM drives en, up_dn and the loads.

## Test plan
- ONESHOT lo=2 hi=4: cnt 2,3,4,3,2; done pulses once after edge 5; busy drops; laps=1.
- WRAP_UP lo=0 hi=7 for 17 edges: cnt wraps 7→0 twice; laps=2. Then stop: cnt frozen, busy=0.
- BOUNCE lo=1 hi=3 with hold high for 3 cycles mid-UP: cnt and laps frozen during hold, then the sequence resumes from the same value.
- start with lo=5 hi=2: err pulses once, state stays IDLE, cnt unchanged. Also: start and stop in the same cycle gives no action.
- Edge cases:
  - lo==hi=6 in BOUNCE: cnt stays 6 and laps increments every 2 edges.
  - rst asserted mid-DOWN: cnt=0, up_dn=1, laps=0 next cycle.
- laps saturation: WRAP_DN lo=hi−1 run for 40 edges; laps holds at 15.

Source files
------------

// File: rtl/updn_sweep_pkg.sv
// Shared encodings for the up/down sweep controller: sweep modes and FSM states.
package updn_sweep_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP_UP = 2'b00,
        MODE_WRAP_DN = 2'b01,
        MODE_BOUNCE  = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10
    } state_e;

    // Wrap modes restart at the far bound; bounce and one-shot reverse direction instead.
    function automatic logic is_wrap_mode(input mode_e m);
        return (m == MODE_WRAP_UP) || (m == MODE_WRAP_DN);
    endfunction

endpackage

// File: rtl/updn_sweep_ctrl_if.sv
// Control/status bundle between the sweep controller and whatever sequences it.
interface updn_sweep_ctrl_if #(
    parameter int W    = 3,
    parameter int LAPW = 4
);
    logic            start;
    logic            stop;
    logic            hold;
    logic [1:0]      mode;
    logic [W-1:0]    lo;
    logic [W-1:0]    hi;
    logic [W-1:0]    cnt;
    logic            up_dn;
    logic            busy;
    logic            done;
    logic            err;
    logic [LAPW-1:0] laps;

    modport master (
        output start, stop, hold, mode, lo, hi,
        input  cnt, up_dn, busy, done, err, laps
    );

    modport slave (
        input  start, stop, hold, mode, lo, hi,
        output cnt, up_dn, busy, done, err, laps
    );
endinterface

// File: rtl/updn_cnt_ld.sv
// Loadable W-bit up/down counter; the load has priority over counting.
module updn_cnt_ld #(
    parameter int W = 3
) (
    input  logic         slow_clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up_dn,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] cnt
);

    always_ff @(posedge slow_clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (en) begin
            cnt <= up_dn ? cnt + W'(1) : cnt - W'(1);
        end
    end

endmodule

// File: rtl/updn_sweep_ctrl.sv
// Sweep sequencer for the 3-bit LED counter: steps cnt between latched bounds
// in wrap, bounce or one-shot patterns, with lap counting and status pulses.
module updn_sweep_ctrl #(
    parameter int W    = 3,
    parameter int LAPW = 4
) (
    input  logic             slow_clk,
    input  logic             rst,
    updn_sweep_ctrl_if.slave bus
);
    import updn_sweep_pkg::*;

    state_e          state_q, state_n;
    mode_e           mode_q, mode_n;
    logic [W-1:0]    lo_q, lo_n;
    logic [W-1:0]    hi_q, hi_n;
    logic [LAPW-1:0] laps_q, laps_n;
    logic            up_dn_q, up_dn_n;
    logic            busy_q, busy_n;
    logic            done_q, done_n;
    logic            err_q, err_n;

    logic            cnt_en;
    logic            cnt_up;
    logic            cnt_ld;
    logic [W-1:0]    cnt_ld_val;
    logic [W-1:0]    cnt;
    logic [LAPW-1:0] laps_bumped;
    mode_e           mode_in;

    assign mode_in     = mode_e'(bus.mode);
    assign laps_bumped = (laps_q == {LAPW{1'b1}}) ? laps_q : laps_q + LAPW'(1);

    updn_cnt_ld #(.W(W)) u_cnt (
        .slow_clk (slow_clk),
        .rst      (rst),
        .en       (cnt_en),
        .up_dn    (cnt_up),
        .ld       (cnt_ld),
        .ld_val   (cnt_ld_val),
        .cnt      (cnt)
    );

    always_ff @(posedge slow_clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_WRAP_UP;
            lo_q    <= '0;
            hi_q    <= '0;
            laps_q  <= '0;
            up_dn_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            mode_q  <= mode_n;
            lo_q    <= lo_n;
            hi_q    <= hi_n;
            laps_q  <= laps_n;
            up_dn_q <= up_dn_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            err_q   <= err_n;
        end
    end

    // Turnarounds step straight off the bound, so each bound shows for one cycle;
    // when lo==hi the step is suppressed and only the direction flips.
    always_comb begin
        state_n    = state_q;
        mode_n     = mode_q;
        lo_n       = lo_q;
        hi_n       = hi_q;
        laps_n     = laps_q;
        up_dn_n    = up_dn_q;
        busy_n     = busy_q;
        done_n     = 1'b0;
        err_n      = 1'b0;
        cnt_en     = 1'b0;
        cnt_up     = up_dn_q;
        cnt_ld     = 1'b0;
        cnt_ld_val = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    if (bus.lo <= bus.hi) begin
                        mode_n = mode_in;
                        lo_n   = bus.lo;
                        hi_n   = bus.hi;
                        laps_n = '0;
                        busy_n = 1'b1;
                        cnt_ld = 1'b1;
                        if (mode_in == MODE_WRAP_DN) begin
                            cnt_ld_val = bus.hi;
                            state_n    = ST_DOWN;
                            up_dn_n    = 1'b0;
                        end else begin
                            cnt_ld_val = bus.lo;
                            state_n    = ST_UP;
                            up_dn_n    = 1'b1;
                        end
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end

            ST_UP: begin
                if (bus.stop) begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                end else if (!bus.hold) begin
                    if (cnt < hi_q) begin
                        cnt_en = 1'b1;
                        cnt_up = 1'b1;
                    end else if (is_wrap_mode(mode_q)) begin
                        cnt_ld     = 1'b1;
                        cnt_ld_val = lo_q;
                        laps_n     = laps_bumped;
                    end else begin
                        cnt_en  = (lo_q != hi_q);
                        cnt_up  = 1'b0;
                        state_n = ST_DOWN;
                        up_dn_n = 1'b0;
                    end
                end
            end

            ST_DOWN: begin
                if (bus.stop) begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                end else if (!bus.hold) begin
                    if (cnt > lo_q) begin
                        cnt_en = 1'b1;
                        cnt_up = 1'b0;
                    end else begin
                        laps_n = laps_bumped;
                        if (mode_q == MODE_ONESHOT) begin
                            state_n = ST_IDLE;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end else if (is_wrap_mode(mode_q)) begin
                            cnt_ld     = 1'b1;
                            cnt_ld_val = hi_q;
                        end else begin
                            cnt_en  = (lo_q != hi_q);
                            cnt_up  = 1'b1;
                            state_n = ST_UP;
                            up_dn_n = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign bus.cnt   = cnt;
    assign bus.up_dn = up_dn_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.laps  = laps_q;

endmodule
